// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline control sequencer:
// FSM state encodings and the x0 register index.
package branch_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/branch_hazard_ctrl_load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination
// feeds a source operand of the instruction in ID.
module load_use_detect
    import branch_hazard_ctrl_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    output logic       hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_use_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit = id_use_rs2 & (id_rs2 == ex_rd);

    // x0 never carries a value, so a load to it cannot cause a hazard
    assign hazard = ex_valid & ex_mem_read & (ex_rd != REG_X0)
                  & (rs1_hit | rs2_hit);

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Pipeline control sequencer: PC redirect, stage stall and flush.
// Optional BRANCH_PERF_EN adds branch/taken/stall counters.
module branch_hazard_ctrl
    import branch_hazard_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int FLUSH_EXTRA = 0,
    parameter int CNT_W       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            jump_flag,
    input  logic [XLEN-1:0] jump_target,
    input  logic            ex_mem_read,
    input  logic [4:0]      ex_rd,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic            mem_busy,
    output logic            pc_sel,
    output logic [XLEN-1:0] pc_target,
    output logic            pc_stall,
    output logic            ifid_stall,
    output logic            ifid_flush,
    output logic            idex_stall,
    output logic            idex_flush,
    output logic            exmem_stall,
    output logic [1:0]      state_o
`ifdef BRANCH_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_branch,
    output logic [CNT_W-1:0] perf_taken,
    output logic [CNT_W-1:0] perf_stall
`endif
);

    localparam logic [2:0] CNT_LOAD = 3'(FLUSH_EXTRA);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    logic hazard;
    logic run_eval;
    logic freeze;
    logic redirect;
    logic lu_stall;
    logic flush_hold;

    load_use_detect u_lud (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .hazard      (hazard)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        run_eval   = 1'b0;
        freeze     = 1'b0;
        redirect   = 1'b0;
        lu_stall   = 1'b0;
        flush_hold = 1'b0;

        case (state_q)
            ST_FLUSH: begin
                flush_hold = 1'b1;
                if (mem_busy) begin
                    freeze = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_MEMWAIT: begin
                if (mem_busy) begin
                    freeze = 1'b1;
                end else begin
                    run_eval = 1'b1;
                end
            end
            default: run_eval = 1'b1;
        endcase

        // MEMWAIT exit cycle is handled exactly like a RUN cycle
        if (run_eval) begin
            state_d = ST_RUN;
            if (mem_busy) begin
                freeze  = 1'b1;
                state_d = ST_MEMWAIT;
            end else if (ex_valid & jump_flag) begin
                redirect = 1'b1;
                if (FLUSH_EXTRA > 0) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_LOAD;
                end
            end else if (hazard) begin
                lu_stall = 1'b1;
            end
        end
    end

    assign pc_sel      = redirect;
    assign pc_target   = redirect ? jump_target : '0;
    assign pc_stall    = freeze | lu_stall;
    assign ifid_stall  = freeze | lu_stall;
    assign ifid_flush  = redirect | flush_hold;
    assign idex_stall  = freeze;
    assign idex_flush  = redirect | lu_stall;
    assign exmem_stall = freeze;
    assign state_o     = state_q;

`ifdef BRANCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branch <= '0;
            perf_taken  <= '0;
            perf_stall  <= '0;
        end else begin
            if (run_eval & ex_valid & ex_is_branch & !mem_busy) begin
                perf_branch <= perf_branch + CNT_W'(1);
            end
            if (redirect) begin
                perf_taken <= perf_taken + CNT_W'(1);
            end
            if (pc_stall) begin
                perf_stall <= perf_stall + CNT_W'(1);
            end
        end
    end
`else
    logic unused_sink;
    assign unused_sink = ex_is_branch ^ (CNT_W == 0);
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Self-checking bench for branch_hazard_ctrl: table-driven single-cycle
// vectors plus hand-written multi-cycle sequences.
module tb_branch_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        jump_flag;
    logic [31:0] jump_target;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic        mem_busy;

    logic        pc_sel0, pc_stall0, ifid_stall0, ifid_flush0;
    logic        idex_stall0, idex_flush0, exmem_stall0;
    logic [31:0] pc_target0;
    logic [1:0]  state0;

    logic        pc_sel2, pc_stall2, ifid_stall2, ifid_flush2;
    logic        idex_stall2, idex_flush2, exmem_stall2;
    logic [31:0] pc_target2;
    logic [1:0]  state2;

`ifdef BRANCH_PERF_EN
    logic [31:0] perf_branch0, perf_taken0, perf_stall0;
    logic [31:0] perf_branch2, perf_taken2, perf_stall2;
`endif

    logic [6:0] ctl0;
    logic [6:0] ctl2;

    assign ctl0 = {pc_sel0, pc_stall0, ifid_stall0, ifid_flush0,
                   idex_stall0, idex_flush0, exmem_stall0};
    assign ctl2 = {pc_sel2, pc_stall2, ifid_stall2, ifid_flush2,
                   idex_stall2, idex_flush2, exmem_stall2};

    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_JUMP  = 7'b1001010;
    localparam logic [6:0] C_LU    = 7'b0110010;
    localparam logic [6:0] C_FRZ   = 7'b0110101;
    localparam logic [6:0] C_FLUSH = 7'b0001000;
    localparam logic [6:0] C_FRZFL = 7'b0111101;

    branch_hazard_ctrl #(.XLEN(32), .FLUSH_EXTRA(0), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .jump_flag(jump_flag), .jump_target(jump_target),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .mem_busy(mem_busy),
        .pc_sel(pc_sel0), .pc_target(pc_target0),
        .pc_stall(pc_stall0), .ifid_stall(ifid_stall0),
        .ifid_flush(ifid_flush0), .idex_stall(idex_stall0),
        .idex_flush(idex_flush0), .exmem_stall(exmem_stall0),
        .state_o(state0)
`ifdef BRANCH_PERF_EN
        , .perf_branch(perf_branch0), .perf_taken(perf_taken0),
        .perf_stall(perf_stall0)
`endif
    );

    branch_hazard_ctrl #(.XLEN(32), .FLUSH_EXTRA(2), .CNT_W(32)) dut2 (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .jump_flag(jump_flag), .jump_target(jump_target),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .mem_busy(mem_busy),
        .pc_sel(pc_sel2), .pc_target(pc_target2),
        .pc_stall(pc_stall2), .ifid_stall(ifid_stall2),
        .ifid_flush(ifid_flush2), .idex_stall(idex_stall2),
        .idex_flush(idex_flush2), .exmem_stall(exmem_stall2),
        .state_o(state2)
`ifdef BRANCH_PERF_EN
        , .perf_branch(perf_branch2), .perf_taken(perf_taken2),
        .perf_stall(perf_stall2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ev;
        logic        br;
        logic        jf;
        logic [31:0] tgt;
        logic        mr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic        busy;
        logic [6:0]  exp_ctl;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t tv [12];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic set_in(input logic ev, input logic br, input logic jf,
                          input logic [31:0] tgt, input logic mr,
                          input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic busy);
        ex_valid     = ev;
        ex_is_branch = br;
        jump_flag    = jf;
        jump_target  = tgt;
        ex_mem_read  = mr;
        ex_rd        = rd;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_use_rs1   = u1;
        id_use_rs2   = u2;
        mem_busy     = busy;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    endtask

    task automatic jump(input logic [31:0] t);
        set_in(1, 1, 1, t, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    endtask

    // start of a cycle: just after the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // sample point: mid-cycle, away from the edge
    task automatic mid();
        #4;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        idle();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();

        tv[0]  = '{0,0,0,32'h0,       0,5'd0,5'd0,5'd0,0,0,0, C_NONE, 32'h0};
        tv[1]  = '{1,1,1,32'h100,     0,5'd0,5'd0,5'd0,0,0,0, C_JUMP, 32'h100};
        tv[2]  = '{0,1,1,32'h200,     0,5'd0,5'd0,5'd0,0,0,0, C_NONE, 32'h0};
        tv[3]  = '{1,0,0,32'h0,       1,5'd5,5'd0,5'd5,0,1,0, C_LU,   32'h0};
        tv[4]  = '{1,0,0,32'h0,       1,5'd7,5'd7,5'd1,1,0,0, C_LU,   32'h0};
        tv[5]  = '{1,0,0,32'h0,       1,5'd0,5'd0,5'd0,1,1,0, C_NONE, 32'h0};
        tv[6]  = '{1,0,0,32'h0,       1,5'd5,5'd0,5'd5,0,0,0, C_NONE, 32'h0};
        tv[7]  = '{0,0,0,32'h0,       0,5'd0,5'd0,5'd0,0,0,1, C_FRZ,  32'h0};
        tv[8]  = '{1,1,1,32'h400,     1,5'd3,5'd3,5'd0,1,0,0, C_JUMP, 32'h400};
        tv[9]  = '{1,1,1,32'h500,     0,5'd0,5'd0,5'd0,0,0,1, C_FRZ,  32'h0};
        tv[10] = '{1,0,0,32'h0,       0,5'd9,5'd9,5'd9,1,1,0, C_NONE, 32'h0};
        tv[11] = '{1,1,1,32'hDEADBEE0,1,5'd4,5'd0,5'd4,0,1,0, C_JUMP, 32'hDEADBEE0};

        // reset with random inputs held for two cycles
        for (int i = 0; i < 2; i++) begin
            cyc();
            set_in($urandom, $urandom, $urandom, $urandom, $urandom,
                   5'($urandom), 5'($urandom), 5'($urandom),
                   $urandom, $urandom, $urandom);
        end
        cyc();
        rst = 1'b0;
        idle();
        mid();
        chk("reset_state0", 64'(state0), 64'd0);
        chk("reset_ctl0", 64'(ctl0), 64'(C_NONE));
        chk("reset_tgt0", 64'(pc_target0), 64'd0);
        chk("reset_state2", 64'(state2), 64'd0);
        chk("reset_ctl2", 64'(ctl2), 64'(C_NONE));

        // single-cycle vectors from RUN, each followed by an idle cycle
        for (int i = 0; i < 12; i++) begin
            cyc();
            set_in(tv[i].ev, tv[i].br, tv[i].jf, tv[i].tgt, tv[i].mr,
                   tv[i].rd, tv[i].rs1, tv[i].rs2, tv[i].u1, tv[i].u2,
                   tv[i].busy);
            mid();
            chk($sformatf("vec%0d_ctl", i), 64'(ctl0), 64'(tv[i].exp_ctl));
            chk($sformatf("vec%0d_tgt", i), 64'(pc_target0),
                64'(tv[i].exp_tgt));
            cyc();
            idle();
        end

        // taken branch then quiet cycle
        do_reset();
        jump(32'h100);
        mid();
        chk("beq_ctl", 64'(ctl0), 64'(C_JUMP));
        chk("beq_tgt", 64'(pc_target0), 64'h100);
        cyc();
        idle();
        mid();
        chk("beq_after_ctl", 64'(ctl0), 64'(C_NONE));
        chk("beq_after_state", 64'(state0), 64'd0);

        // jump held in EX across a three-cycle memory freeze
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 1, 32'h80, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
            mid();
            chk($sformatf("frz%0d_ctl", i), 64'(ctl0), 64'(C_FRZ));
            chk($sformatf("frz%0d_state", i), 64'(state0),
                (i == 0) ? 64'd0 : 64'd2);
            cyc();
        end
        jump(32'h80);
        mid();
        chk("frz_exit_ctl", 64'(ctl0), 64'(C_JUMP));
        chk("frz_exit_tgt", 64'(pc_target0), 64'h80);
        chk("frz_exit_state", 64'(state0), 64'd2);
        cyc();
        idle();
        mid();
        chk("frz_done_state", 64'(state0), 64'd0);

        // FLUSH_EXTRA=2: three cycles of IF/ID flush
        do_reset();
        jump(32'h300);
        mid();
        chk("fx_c0_ctl", 64'(ctl2), 64'(C_JUMP));
        chk("fx_c0_state", 64'(state2), 64'd0);
        for (int i = 1; i <= 2; i++) begin
            cyc();
            idle();
            mid();
            chk($sformatf("fx_c%0d_ctl", i), 64'(ctl2), 64'(C_FLUSH));
            chk($sformatf("fx_c%0d_state", i), 64'(state2), 64'd1);
        end
        cyc();
        mid();
        chk("fx_c3_ctl", 64'(ctl2), 64'(C_NONE));
        chk("fx_c3_state", 64'(state2), 64'd0);

        // jump plus load-use on the FLUSH_EXTRA=2 instance
        do_reset();
        set_in(1, 1, 1, 32'h44, 1, 5'd6, 5'd6, 5'd0, 1, 0, 0);
        mid();
        chk("fx_jlu_ctl", 64'(ctl2), 64'(C_JUMP));
        chk("fx_jlu_pcstall", 64'(pc_stall2), 64'd0);

        // memory freeze inside FLUSH holds the counter
        do_reset();
        jump(32'h600);
        cyc();
        set_in(0, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        mid();
        chk("fxb_frz_ctl", 64'(ctl2), 64'(C_FRZFL));
        chk("fxb_frz_state", 64'(state2), 64'd1);
        cyc();
        idle();
        mid();
        chk("fxb_c2_state", 64'(state2), 64'd1);
        cyc();
        mid();
        chk("fxb_c3_state", 64'(state2), 64'd1);
        chk("fxb_c3_ctl", 64'(ctl2), 64'(C_FLUSH));
        cyc();
        mid();
        chk("fxb_c4_state", 64'(state2), 64'd0);

        // reset in the middle of FLUSH
        do_reset();
        jump(32'h700);
        cyc();
        rst = 1'b1;
        idle();
        mid();
        chk("rstfl_pre_state", 64'(state2), 64'd1);
        cyc();
        rst = 1'b0;
        mid();
        chk("rstfl_state", 64'(state2), 64'd0);
        chk("rstfl_ctl", 64'(ctl2), 64'(C_NONE));

        // reset in the middle of MEMWAIT
        do_reset();
        set_in(0, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        idle();
        mid();
        chk("rstmw_state", 64'(state0), 64'd0);

`ifdef BRANCH_PERF_EN
        do_reset();
        mid();
        chk("perf_clr_branch", 64'(perf_branch0), 64'd0);
        jump(32'h10);
        cyc(); idle();
        cyc(); set_in(1, 1, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        cyc(); idle();
        cyc(); jump(32'h20);
        cyc(); idle();
        cyc(); set_in(1, 1, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        cyc(); idle();
        cyc(); set_in(1, 0, 0, 32'h0, 1, 5'd5, 5'd0, 5'd5, 0, 1, 0);
        cyc(); idle();
        mid();
        chk("perf_branch", 64'(perf_branch0), 64'd4);
        chk("perf_taken", 64'(perf_taken0), 64'd2);
        chk("perf_stall", 64'(perf_stall0), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
